step_pulse_gen: RTL

- Receive-side companion to the system clock divider.
- Takes an asynchronous, bouncy board pushbutton in the fast board-clock domain.
- Produces a debounced level and a single-cycle step pulse, used as the multi-cycle CPU's manual single-step clock enable.
- Also keeps a 16-bit count of accepted presses for the seven-segment display path.

---
 rtl/step_pulse_gen_pkg.sv | 20 ++
 rtl/step_pulse_gen_sync_2ff.sv | 23 ++
 rtl/step_pulse_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/step_pulse_gen_pkg.sv
// Shared types and constants for the pushbutton step-pulse generator.
package step_pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF = 26;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced pushbutton -> single-cycle step pulse plus press counter.
// Optional auto-repeat while held: define STEP_PULSE_AUTO_REPEAT_EN.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | button seen high, counting stable samples
// PRESSED      | press accepted, button held (repeat timer runs if enabled)
// RELEASE_WAIT | button seen low, counting stable samples
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_in,
  output logic        btn_level,
  output logic        step_pulse,
  output logic [15:0] press_count
);

  localparam int unsigned MAX_TC = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  if ($clog2(MAX_TC + 1) > CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [15:0]      count_q, count_d;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_s)
  );

`ifdef STEP_PULSE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_TC = CNT_W'(REPEAT_PERIOD - 1);
  // Set once the first repeat has fired: later repeats use the shorter period.
  logic rpt_q, rpt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_q <= 1'b0;
    else        rpt_q <= rpt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    count_d = count_q;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
          count_d = count_q + 16'd1;
          cnt_d   = '0;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
          rpt_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
`ifdef STEP_PULSE_AUTO_REPEAT_EN
          if (cnt_q == (rpt_q ? RP_TC : RD_TC)) begin
            pulse_d = 1'b1;
            count_d = count_q + 16'd1;
            cnt_d   = '0;
            rpt_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_q;
  assign step_pulse  = pulse_q;
  assign press_count = count_q;

endmodule
